// File: rtl/dlx_pkg.sv
// Shared DLX definitions: FP op codes, sequencer states
// and default execute latencies for the multi-cycle FP unit.
package dlx_pkg;

  localparam logic [4:0] OP_ADDF   = 5'b01111;
  localparam logic [4:0] OP_CVTF2I = 5'b11111;
  localparam logic [4:0] OP_CVTI2F = 5'b11110;

  localparam int LAT_ADD_DEF = 4;
  localparam int LAT_CVT_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } state_e;

  function automatic logic is_cvt(
    input logic [4:0] op
  );
    return (op == OP_CVTF2I) ||
           (op == OP_CVTI2F);
  endfunction

  function automatic logic op_known(
    input logic [4:0] op
  );
    return (op == OP_ADDF) || is_cvt(op);
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// FP register pending mask: one set port, one clear
// port, three combinational lookups.
module fp_scoreboard (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rd1_idx,
  input  logic [4:0] rd2_idx,
  input  logic [4:0] wr_idx,
  output logic       rd1_pend,
  output logic       rd2_pend,
  output logic       wr_pend
);

  logic [31:0] pending;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign set_mask = set_en ? (32'd1 << set_idx)
                           : 32'd0;
  assign clr_mask = clr_en ? (32'd1 << clr_idx)
                           : 32'd0;

  // set is applied after clear so it wins on a collision
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign rd1_pend = pending[rd1_idx];
  assign rd2_pend = pending[rd2_idx];
  assign wr_pend  = pending[wr_idx];

endmodule

// File: rtl/multicycle_seq.sv
// Issue sequencer for the shared, non-pipelined FP unit:
// hazard stall, launch, countdown and write-back strobe.
module multicycle_seq
  import dlx_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_CVT = LAT_CVT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       issue_valid,
  input  logic [4:0] issue_op,
  input  logic [4:0] issue_dst,
  input  logic [4:0] issue_src1,
  input  logic [4:0] issue_src2,
  input  logic       fp_read,
  input  logic       fp_write,
  input  logic       kill,
  output logic       stall,
  output logic       unit_start,
  output logic [4:0] unit_op,
  output logic       wb_valid,
  output logic [4:0] wb_dst,
  output logic       busy,
  output logic       err_illegal
);

  state_e     state;
  state_e     state_nx;
  logic [7:0] cnt;
  logic [7:0] lat_sel;
  logic [4:0] dst_q;
  logic       in_busy;
  logic       in_wb;
  logic       hazard;
  logic       accept;
  logic       p1;
  logic       p2;
  logic       pd;

  fp_scoreboard u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (accept),
    .set_idx  (issue_dst),
    .clr_en   (in_wb),
    .clr_idx  (dst_q),
    .rd1_idx  (issue_src1),
    .rd2_idx  (issue_src2),
    .wr_idx   (issue_dst),
    .rd1_pend (p1),
    .rd2_pend (p2),
    .wr_pend  (pd)
  );

  assign in_busy = (state == S_BUSY);
  assign in_wb   = (state == S_WB);

  assign hazard = (fp_read & (p1 | p2)) |
                  (fp_write & pd);

  assign stall = ~kill &
                 (hazard | (issue_valid & in_busy));

  assign accept = issue_valid & ~kill &
                  ~stall & ~in_busy;

  always_comb begin
    lat_sel = 8'(LAT_ADD);
    unique case (1'b1)
      is_cvt(issue_op): lat_sel = 8'(LAT_CVT);
      default:          lat_sel = 8'(LAT_ADD);
    endcase
  end

  // <= 1 keeps a zero latency from wrapping the counter
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_BUSY;
      S_BUSY: if (cnt <= 8'd1) state_nx = S_WB;
      S_WB:   state_nx = accept ? S_BUSY : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      unit_op     <= '0;
      dst_q       <= '0;
      unit_start  <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_nx;
      unit_start  <= accept;
      err_illegal <= accept & ~op_known(issue_op);
      if (accept) begin
        unit_op <= issue_op;
        dst_q   <= issue_dst;
        cnt     <= lat_sel;
      end else if (in_busy) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  assign wb_valid = in_wb;
  assign wb_dst   = dst_q;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq; write-backs are
// checked against a queue of expected (dst, cycle) pairs.
module tb_multicycle_seq;
  import dlx_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       issue_valid;
  logic [4:0] issue_op;
  logic [4:0] issue_dst;
  logic [4:0] issue_src1;
  logic [4:0] issue_src2;
  logic       fp_read;
  logic       fp_write;
  logic       kill;
  logic       stall;
  logic       unit_start;
  logic [4:0] unit_op;
  logic       wb_valid;
  logic [4:0] wb_dst;
  logic       busy;
  logic       err_illegal;

  typedef struct {
    logic [4:0] dst;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_chk;
  int   n_pass;

  multicycle_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_dst   (issue_dst),
    .issue_src1  (issue_src1),
    .issue_src2  (issue_src2),
    .fp_read     (fp_read),
    .fp_write    (fp_write),
    .kill        (kill),
    .stall       (stall),
    .unit_start  (unit_start),
    .unit_op     (unit_op),
    .wb_valid    (wb_valid),
    .wb_dst      (wb_dst),
    .busy        (busy),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [4:0] op,
    input logic [4:0] dst,
    input logic [4:0] s1,
    input logic [4:0] s2
  );
    issue_valid = 1'b1;
    issue_op    = op;
    issue_dst   = dst;
    issue_src1  = s1;
    issue_src2  = s2;
    fp_read     = 1'b1;
    fp_write    = 1'b1;
    kill        = 1'b0;
  endtask

  task automatic idle_in();
    issue_valid = 1'b0;
    issue_op    = '0;
    issue_dst   = '0;
    issue_src1  = '0;
    issue_src2  = '0;
    fp_read     = 1'b0;
    fp_write    = 1'b0;
    kill        = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_timeout", busy, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && wb_valid) begin
      if (q.size() == 0) begin
        chk("wb_unexpected", wb_dst, 5'h1f);
        chk("wb_unexp_flag", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_dst", wb_dst, e.dst);
        chk("wb_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    idle_in();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", unit_start, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_unit_op", unit_op, 0);
    chk("rst_wb_dst", wb_dst, 0);
    tick();

    // basic ADDF latency
    drive(OP_ADDF, 5'd3, 5'd1, 5'd2);
    #1;
    chk("t1_stall", stall, 0);
    q.push_back('{5'd3, cyc + 5});
    tick();
    idle_in();
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk("t1_start", unit_start, k == 1);
      chk("t1_busy", busy, k <= 5);
      chk("t1_wb", wb_valid, k == 5);
      chk("t1_err", err_illegal, 0);
      if (k == 1) chk("t1_op", unit_op, OP_ADDF);
      tick();
    end

    // RAW on the completing register: no bypass
    drive(OP_ADDF, 5'd3, 5'd1, 5'd2);
    #1;
    q.push_back('{5'd3, cyc + 5});
    tick();
    idle_in();
    fp_read    = 1'b1;
    issue_src1 = 5'd3;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk("t2_stall", stall, k <= 5);
      tick();
    end
    idle_in();
    wait_idle();

    // structural stall, accept in WB
    drive(OP_CVTF2I, 5'd7, 5'd8, 5'd9);
    #1;
    q.push_back('{5'd7, cyc + 3});
    tick();
    drive(OP_ADDF, 5'd9, 5'd10, 5'd11);
    for (int k = 1; k <= 2; k++) begin
      #1;
      chk("t3_stall_busy", stall, 1);
      tick();
    end
    #1;
    chk("t3_stall_wb", stall, 0);
    chk("t3_wb", wb_valid, 1);
    q.push_back('{5'd9, cyc + 5});
    tick();
    idle_in();
    #1;
    chk("t3_start", unit_start, 1);
    chk("t3_busy", busy, 1);
    chk("t3_op", unit_op, OP_ADDF);
    wait_idle();

    // kill overrides a hazard and blocks accept
    drive(OP_ADDF, 5'd4, 5'd1, 5'd2);
    #1;
    q.push_back('{5'd4, cyc + 5});
    tick();
    drive(OP_ADDF, 5'd5, 5'd4, 5'd6);
    kill = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("t4_stall", stall, 0);
      tick();
    end
    #1;
    chk("t4_start", unit_start, 0);
    chk("t4_busy", busy, 0);
    tick();
    #1;
    chk("t4_busy2", busy, 0);
    idle_in();
    tick();

    // reset aborts an in-flight op
    drive(OP_ADDF, 5'd3, 5'd1, 5'd2);
    #1;
    q.push_back('{5'd3, cyc + 5});
    tick();
    idle_in();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    q.delete();
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_stall0", stall, 0);
    drive(OP_ADDF, 5'd3, 5'd3, 5'd3);
    #1;
    chk("t5_stall", stall, 0);
    chk("t5_wb", wb_valid, 0);
    q.push_back('{5'd3, cyc + 5});
    tick();
    idle_in();
    #1;
    chk("t5_start", unit_start, 1);
    wait_idle();

    // unrecognised op: error pulse, ADD latency
    drive(5'b00101, 5'd12, 5'd13, 5'd14);
    #1;
    q.push_back('{5'd12, cyc + 5});
    tick();
    idle_in();
    #1;
    chk("t6_err", err_illegal, 1);
    chk("t6_op", unit_op, 5'b00101);
    tick();
    #1;
    chk("t6_err_pulse", err_illegal, 0);
    wait_idle();

    // CVTI2F uses the short latency
    drive(OP_CVTI2F, 5'd1, 5'd2, 5'd3);
    #1;
    q.push_back('{5'd1, cyc + 3});
    tick();
    idle_in();
    #1;
    chk("t7_err", err_illegal, 0);
    wait_idle();
    tick();

    chk("q_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
